ppu_pixel_out: RTL
==================

Name: ppu_pixel_out

Overview:
- Final PPU pixel stage, sitting directly upstream of the 32-byte palette RAM. It owns that RAM's single address/write port.
- Converts each rendered pixel's 5-bit palette address into a 6-bit NES colour, applies PPUMASK greyscale and emphasis, and emits a registered pixel stream to the video/line-buffer logic.
- Arbitrates CPU $2007 palette accesses into free cycles, and generates scanline/frame strobes.

Parameters:
- LAST_X, 255, final visible pixel column
- LAST_Y, 239, final visible scanline

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- clk_en  in  1  PPU clock enable (1 of every 4 clk cycles)
- pix_valid  in  1  pixel present; qualified by clk_en
- pix_x  in  8  pixel column
- pix_y  in  8  pixel row
- pix_pal_addr  in  5  palette address from bg/sprite priority mux
- mask_grey  in  1  PPUMASK greyscale bit
- mask_emph  in  3  PPUMASK emphasis bits {B,G,R}
- cpu_req  in  1  CPU palette access request; level, held until cpu_ack
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  5  CPU palette address
- cpu_wdata  in  8  CPU write data
- cpu_ack  out  1  one-cycle completion pulse
- cpu_rdata  out  8  read data; valid when cpu_ack is high, then held
- pal_addr  out  5  palette RAM address
- pal_we  out  1  palette RAM write enable
- pal_wdata  out  8  palette RAM write data
- pal_rdata  in  8  palette RAM combinational read data
- out_valid  out  1  one-cycle pixel strobe
- out_x  out  8  pixel column
- out_y  out  8  pixel row
- out_color  out  6  NES colour index
- out_emph  out  3  emphasis bits
- line_done  out  1  one-cycle pulse with the last pixel of a line
- frame_done  out  1  one-cycle pulse with the last pixel of a frame
- seq_err  out  1  sticky pixel-ordering error

Behaviour:
- Reset (rst sampled high at posedge clk): every registered output goes to 0, the expected-x counter goes to 0, and any in-flight CPU request is dropped without an ack. A CPU request still held after reset is serviced normally.
- Pixel slot: any cycle with clk_en && pix_valid.
  - pal_addr = pix_pal_addr when pix_pal_addr[1:0] != 0; otherwise pal_addr = 5'h00 (backdrop).
  - pal_we = 0.
- Pixel output, 1 clk latency from the pixel slot:
  - out_valid = 1 for exactly one clk cycle.
  - out_color = pal_rdata[5:0] & (mask_grey ? 6'h30 : 6'h3F).
  - out_emph, out_x and out_y are the values sampled in the slot.
  - In all other cycles out_valid = 0 and the data outputs hold their last values.
- CPU slot: any cycle that is not a pixel slot and has cpu_req high with no ack issued in the previous cycle.
  - pal_addr = mirrored cpu_addr: if cpu_addr[1:0] == 0, then bit 4 is cleared (so 10/14/18/1C map to 00/04/08/0C).
  - Write: pal_we = cpu_we for that single cycle; pal_wdata = cpu_wdata.
  - Read: cpu_rdata = {2'b00, pal_rdata[5:0]}, registered.
  - cpu_ack pulses high on the next cycle, exactly once per request.
- Back-to-back requests: the CPU must drop cpu_req or change the request in the cycle cpu_ack is high. The no-ack-previous-cycle rule prevents double service.
- Priority: a pixel slot always wins. A CPU request that collides with a pixel slot is serviced in the next free cycle, so worst-case CPU latency is 2 clk.
- Idle: in any cycle with neither a pixel slot nor a CPU slot, pal_we = 0 and pal_addr = 0.
- Sequence check:
  - The expected-x counter increments on each pixel slot and wraps to 0 after LAST_X.
  - A pixel slot with pix_x != expected-x sets seq_err, which stays set until rst. The counter then resynchronises to pix_x+1.
- Strobes:
  - line_done = out_valid && out_x == LAST_X.
  - frame_done = line_done && out_y == LAST_Y.
  - Both are registered alongside out_valid, so they are coincident with it.
- Simultaneous events: CPU write and pixel read of the same address in one clk cannot happen (pixel wins). A CPU write completed before a pixel slot is visible to that pixel.

Test Plan:
- Reset: assert rst for 2 clk mid-frame while cpu_req is held -> all outputs 0, and no cpu_ack until a slot after rst deasserts.
- Pixel path: preload RAM[5] = 0x2A; send pixel x=3, y=7, pal_addr=5, grey=0, emph=3'b101 -> next clk shows out_valid=1, out_color=0x2A, out_emph=5, out_x=3, out_y=7.
- Backdrop and greyscale: RAM[0] = 0x16; pixel pal_addr=0x14 with grey=1 -> pal_addr=0x00, out_color=0x10.
- CPU mirroring: CPU write addr=0x1C, data=0x3F during rendering -> RAM[0x0C] = 0x3F. A following CPU read of 0x0C returns cpu_rdata=0x3F with cpu_ack one cycle after the service slot.
- Collision: cpu_req rises in the same cycle as a pixel slot -> pal_addr follows the pixel; CPU is serviced in the next clk and acked 2 clk after the request.
- Line/frame and ordering: stream x=0..255 at y=239 -> single line_done and frame_done pulses with x=255. Then skip x=5 on the next line -> seq_err=1 and stays set.

Source files
------------

// File: rtl/ppu_pixel_out.sv
// Final PPU pixel stage. This block owns the single address/write port of the
// 32-byte palette RAM. It looks up each rendered pixel's colour, applies
// greyscale and emphasis, and emits a registered pixel stream with line and
// frame strobes. CPU $2007 palette accesses are fitted into cycles that carry
// no pixel.
module ppu_pixel_out #(
    parameter logic [7:0] LAST_X = 8'd255,
    parameter logic [7:0] LAST_Y = 8'd239
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clk_en,
    input  logic       pix_valid,
    input  logic [7:0] pix_x,
    input  logic [7:0] pix_y,
    input  logic [4:0] pix_pal_addr,
    input  logic       mask_grey,
    input  logic [2:0] mask_emph,
    input  logic       cpu_req,
    input  logic       cpu_we,
    input  logic [4:0] cpu_addr,
    input  logic [7:0] cpu_wdata,
    output logic       cpu_ack,
    output logic [7:0] cpu_rdata,
    output logic [4:0] pal_addr,
    output logic       pal_we,
    output logic [7:0] pal_wdata,
    input  logic [7:0] pal_rdata,
    output logic       out_valid,
    output logic [7:0] out_x,
    output logic [7:0] out_y,
    output logic [5:0] out_color,
    output logic [2:0] out_emph,
    output logic       line_done,
    output logic       frame_done,
    output logic       seq_err
);

    logic       r_cpu_ack;
    logic [7:0] r_cpu_rdata;
    logic       r_out_valid;
    logic [7:0] r_out_x;
    logic [7:0] r_out_y;
    logic [5:0] r_out_color;
    logic [2:0] r_out_emph;
    logic       r_line_done;
    logic       r_frame_done;
    logic       r_seq_err;
    logic [7:0] r_exp_x;

    logic       w_pix_slot;
    logic       w_cpu_slot;
    logic [4:0] w_pix_addr;
    logic [4:0] w_cpu_addr;
    logic [5:0] w_grey_mask;
    logic [7:0] w_next_x;
    logic       w_last_x;
    logic       w_unused_rdata;

    // The top two palette bits do not exist in the colour space.
    assign w_unused_rdata = ^pal_rdata[7:6];

    // A pixel always takes the RAM port. The CPU gets a cycle only when no
    // pixel is present and it was not just acknowledged: the request line is
    // still high during the ack cycle, and must not be serviced twice.
    // Nothing is serviced while reset is held, so a request pending across
    // reset is dropped and later taken fresh.
    assign w_pix_slot = !rst && clk_en && pix_valid;
    assign w_cpu_slot = !rst && !w_pix_slot && cpu_req && !r_cpu_ack;

    // Entry 0 of each 4-entry palette is the shared backdrop colour.
    assign w_pix_addr = (pix_pal_addr[1:0] != 2'b00) ? pix_pal_addr : 5'h00;

    // Sprite-palette entry 0 mirrors the matching background entry (10->00 etc).
    assign w_cpu_addr = (cpu_addr[1:0] == 2'b00) ? {1'b0, cpu_addr[3:0]} : cpu_addr;

    assign w_grey_mask = mask_grey ? 6'h30 : 6'h3F;
    assign w_last_x    = (pix_x == LAST_X);
    assign w_next_x    = w_last_x ? 8'd0 : pix_x + 8'd1;

    // Palette RAM port arbitration: pixel first, then CPU, otherwise idle at 0.
    always_comb begin
        pal_addr  = 5'h00;
        pal_we    = 1'b0;
        pal_wdata = 8'h00;
        if (w_pix_slot) begin
            pal_addr = w_pix_addr;
        end else if (w_cpu_slot) begin
            pal_addr  = w_cpu_addr;
            pal_we    = cpu_we;
            pal_wdata = cpu_wdata;
        end
    end

    // CPU handshake: a single-cycle ack after each service slot; read data is
    // captured in the slot and held until the next read.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cpu_ack   <= 1'b0;
            r_cpu_rdata <= 8'h00;
        end else begin
            r_cpu_ack <= w_cpu_slot;
            if (w_cpu_slot && !cpu_we) begin
                r_cpu_rdata <= {2'b00, pal_rdata[5:0]};
            end
        end
    end

    // Registered pixel stream. The strobes are derived from the slot's
    // coordinates so they line up with the out_valid they belong to.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_out_x      <= 8'h00;
            r_out_y      <= 8'h00;
            r_out_color  <= 6'h00;
            r_out_emph   <= 3'b000;
            r_line_done  <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_out_valid  <= w_pix_slot;
            r_line_done  <= w_pix_slot && w_last_x;
            r_frame_done <= w_pix_slot && w_last_x && (pix_y == LAST_Y);
            if (w_pix_slot) begin
                r_out_x     <= pix_x;
                r_out_y     <= pix_y;
                r_out_color <= pal_rdata[5:0] & w_grey_mask;
                r_out_emph  <= mask_emph;
            end
        end
    end

    // Pixel-order tracking: flag any column that is not the expected one and
    // resynchronise to the column actually received.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_exp_x   <= 8'h00;
            r_seq_err <= 1'b0;
        end else if (w_pix_slot) begin
            r_exp_x <= w_next_x;
            if (pix_x != r_exp_x) begin
                r_seq_err <= 1'b1;
            end
        end
    end

    assign cpu_ack    = r_cpu_ack;
    assign cpu_rdata  = r_cpu_rdata;
    assign out_valid  = r_out_valid;
    assign out_x      = r_out_x;
    assign out_y      = r_out_y;
    assign out_color  = r_out_color;
    assign out_emph   = r_out_emph;
    assign line_done  = r_line_done;
    assign frame_done = r_frame_done;
    assign seq_err    = r_seq_err;

endmodule
